// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris frame scanner.
package tetris_pkg;

  localparam int unsigned NUM_COLS   = 8;
  localparam int unsigned NUM_ROWS   = 8;
  localparam logic [3:0]  SCORE_SLOT = 4'd8;
  localparam logic [3:0]  DROP_IDLE  = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StCommit
  } cap_state_e;

  // Indexed [column][row]; each column holds its lit-row mask.
  typedef logic [7:0][7:0] frame_t;

endpackage

// File: rtl/tetris_column_decoder.sv
// Maps a {drop_pos, stack_pos} column readout to a row mask.
// With DROP_BLINK_EN the falling pixel is returned separately on drop_mask.
module tetris_column_decoder
  import tetris_pkg::*;
(
  input  logic [7:0] value,
`ifdef DROP_BLINK_EN
  output logic [7:0] drop_mask,
`endif
  output logic [7:0] row_mask
);

  logic [3:0] height;
  logic [3:0] drop;
  logic [7:0] stack_m;
  logic [7:0] drop_m;

  assign height = value[3:0];
  assign drop   = value[7:4];

  // Heights above 8 saturate naturally since r never exceeds 7.
  always_comb begin
    stack_m = '0;
    drop_m  = '0;
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      stack_m[r] = 4'(r) < height;
      drop_m[r]  = (drop < DROP_IDLE) && (drop == 4'(r + 1));
    end
  end

`ifdef DROP_BLINK_EN
  assign drop_mask = drop_m;
  assign row_mask  = stack_m;
`else
  assign row_mask  = stack_m | drop_m;
`endif

endmodule

// File: rtl/tetris_frame_scanner.sv
// Captures the game core's column/score readout into a double-buffered 8x8
// frame and row-scans it onto an LED matrix. Optional feature: DROP_BLINK_EN.
module tetris_frame_scanner
  import tetris_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ROW_HOLD      = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [3:0] update_request_location,
  input  logic [7:0] update_value,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic [7:0] score,
  output logic       frame_done
);

  localparam logic [7:0]  SettleInit = 8'(SETTLE_CYCLES);
  localparam logic [15:0] HoldLast   = 16'(ROW_HOLD - 1);

  cap_state_e state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [7:0] settle_q, settle_d;
  frame_t     shadow_q, disp_q;
  logic [7:0] shadow_score_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] dec_mask;
  logic       sample_en;

`ifdef DROP_BLINK_EN
  frame_t     shadow_drop_q;
  logic [7:0] dec_drop;
`endif

  tetris_column_decoder u_decoder (
    .value    (update_value),
`ifdef DROP_BLINK_EN
    .drop_mask(dec_drop),
`endif
    .row_mask (dec_mask)
  );

  always_comb begin
    state_d                 = state_q;
    slot_d                  = slot_q;
    settle_d                = settle_q;
    update_request_location = 4'd0;
    frame_done              = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          slot_d   = 4'd0;
          settle_d = SettleInit;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        update_request_location = slot_q;
        if (!enable)              state_d = StIdle;
        else if (settle_q == '0)  state_d = StSample;
        else                      settle_d = settle_q - 8'd1;
      end
      StSample: begin
        update_request_location = slot_q;
        if (!enable) begin
          state_d = StIdle;
        end else if (slot_q == SCORE_SLOT) begin
          state_d = StCommit;
        end else begin
          slot_d   = slot_q + 4'd1;
          settle_d = SettleInit;
          state_d  = StSettle;
        end
      end
      StCommit: begin
        frame_done = 1'b1;
        if (enable) begin
          slot_d   = 4'd0;
          settle_d = SettleInit;
          state_d  = StSettle;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sample_en = (state_q == StSample) && enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      slot_q         <= 4'd0;
      settle_q       <= 8'd0;
      shadow_q       <= '0;
      shadow_score_q <= 8'd0;
      disp_q         <= '0;
      score          <= 8'd0;
      frame_cnt_q    <= 8'd0;
`ifdef DROP_BLINK_EN
      shadow_drop_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      settle_q <= settle_d;
      if (sample_en) begin
        if (slot_q == SCORE_SLOT) begin
          shadow_score_q <= update_value;
        end else begin
          shadow_q[slot_q[2:0]] <= dec_mask;
`ifdef DROP_BLINK_EN
          shadow_drop_q[slot_q[2:0]] <= dec_drop;
`endif
        end
      end
      if (state_q == StCommit) begin
`ifdef DROP_BLINK_EN
        // Falling pixels show for 8 frames, hide for 8, keyed on the frame index.
        disp_q <= shadow_q | (frame_cnt_q[3] ? shadow_drop_q : '0);
`else
        disp_q <= shadow_q;
`endif
        score       <= shadow_score_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  logic [15:0] row_timer_q;
  logic [2:0]  row_q, row_next;
  logic        row_wrap;
  logic [7:0]  col_next;

  assign row_wrap = (row_timer_q == HoldLast);
  assign row_next = row_wrap ? row_q + 3'd1 : row_q;

  always_comb begin
    col_next = '0;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      col_next[c] = disp_q[c][row_next];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_timer_q <= 16'd0;
      row_q       <= 3'd0;
      row_sel     <= 8'h01;
      col_data    <= 8'h00;
    end else begin
      row_timer_q <= row_wrap ? 16'd0 : row_timer_q + 16'd1;
      row_q       <= row_next;
      if (row_wrap) row_sel <= {row_sel[6:0], row_sel[7]};
      col_data    <= col_next;
    end
  end

endmodule
